// File: rtl/dft_pkg.sv
// Shared DFT types and defaults: scan FSM state encoding and chain geometry.
package dft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } state_e;

    localparam int DEF_CHAIN_LEN      = 8;
    localparam int DEF_CAPTURE_CYCLES = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/scan_popcount.sv
// Combinational count of masked mismatching bits between two vectors.
module scan_popcount #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [W-1:0]  mask,
    output logic [CW-1:0] count
);

    logic [W-1:0] diff;

    always_comb begin
        diff  = (a ^ b) & mask;
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(diff[i]);
        end
    end

endmodule

// File: rtl/scan_test_ctrl.sv
// Tester-side scan controller: serial load, capture window, serial unload
// and masked compare against an expected response.
module scan_test_ctrl
    import dft_pkg::*;
#(
    parameter int CHAIN_LEN      = DEF_CHAIN_LEN,
    parameter int CAPTURE_CYCLES = DEF_CAPTURE_CYCLES,
    parameter int MW             = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] mask,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] captured,
    output logic [MW-1:0]        mismatch_count
);

    localparam int N  = CHAIN_LEN;
    localparam int CW = $clog2(max_int(CHAIN_LEN, CAPTURE_CYCLES));
    localparam logic [CW-1:0] SHIFT_RL = CW'(CHAIN_LEN - 1);
    localparam logic [CW-1:0] CAP_RL   = CW'(CAPTURE_CYCLES - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   pat_q, pat_d;
    logic [N-1:0]   cap_q, cap_d;
    logic [N-1:0]   exp_q, exp_d;
    logic [N-1:0]   msk_q, msk_d;
    logic [N-1:0]   captured_q, captured_d;
    logic [MW-1:0]  mm_q, mm_d;
    logic           pass_q, pass_d;
    logic           scan_en_q, scan_en_d;
    logic           scan_in_q, scan_in_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   cap_next;
    logic [MW-1:0]  pc;

    // scan_out is sampled before the shift, so the final bit joins here
    assign cap_next = {cap_q[N-2:0], scan_out};

    scan_popcount #(
        .W  (N),
        .CW (MW)
    ) u_popcount (
        .a     (cap_next),
        .b     (exp_q),
        .mask  (msk_q),
        .count (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pat_q      <= '0;
            cap_q      <= '0;
            exp_q      <= '0;
            msk_q      <= '0;
            captured_q <= '0;
            mm_q       <= '0;
            pass_q     <= 1'b0;
            scan_en_q  <= 1'b0;
            scan_in_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pat_q      <= pat_d;
            cap_q      <= cap_d;
            exp_q      <= exp_d;
            msk_q      <= msk_d;
            captured_q <= captured_d;
            mm_q       <= mm_d;
            pass_q     <= pass_d;
            scan_en_q  <= scan_en_d;
            scan_in_q  <= scan_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pat_d      = pat_q;
        cap_d      = cap_q;
        exp_d      = exp_q;
        msk_d      = msk_q;
        captured_d = captured_q;
        mm_d       = mm_q;
        pass_d     = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = SHIFT_RL;
                    pat_d   = {pattern[N-2:0], 1'b0};
                    cap_d   = '0;
                    exp_d   = expected;
                    msk_d   = mask;
                end
            end
            LOAD: begin
                pat_d = {pat_q[N-2:0], 1'b0};
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                    cnt_d   = CAP_RL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                if (cnt_q == '0) begin
                    state_d = UNLOAD;
                    cnt_d   = SHIFT_RL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            UNLOAD: begin
                cap_d = cap_next;
                if (cnt_q == '0) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    captured_d = cap_next;
                    mm_d       = pc;
                    pass_d     = (pc == '0);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_comb begin
        scan_en_d = (state_d == LOAD) || (state_d == UNLOAD);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        scan_in_d = 1'b0;
        if (state_q == IDLE && start) begin
            scan_in_d = pattern[N-1];
        end else if (state_q == LOAD && state_d == LOAD) begin
            scan_in_d = pat_q[N-1];
        end
    end

    assign scan_en        = scan_en_q;
    assign scan_in        = scan_in_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign captured       = captured_q;
    assign mismatch_count = mm_q;

endmodule
